// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: bus widths, size codes, FSM states.
// Latency: none (definitions and pure helper functions only).
// Backpressure: n/a.
package dmem_responder_pkg;

  // Bus widths are expressed as MSB indices, so a port is [ADDR_SIZE:0].
  localparam int ADDR_SIZE  = 31;
  localparam int INSTR_SIZE = 31;

  // Access size encodings on dmem_w_size. The reserved code behaves like a word.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte lanes touched by a write. Half accesses only look at lo[1] and word
  // accesses ignore lo entirely, which is what forces alignment when the
  // misalignment check is compiled out.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << lo;
      SIZE_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

  // Right-aligned write data replicated into every lane so the byte enables
  // alone decide what lands in the word.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {4{d[7:0]}};
      SIZE_HALF: r = {2{d[15:0]}};
      default:   r = d;
    endcase
    return r;
  endfunction

  // True for a half on an odd byte or a word (or reserved) off a word boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic e;
    case (size)
      SIZE_BYTE: e = 1'b0;
      SIZE_HALF: e = lo[0];
      default:   e = |lo;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dmem_responder_sram.sv
// Word-wide storage with per-byte write enables and a registered (synchronous) read port.
// Latency: read data appears the cycle after re_i; writes commit on the clock edge.
// Backpressure: none; always accepts. Contents are deliberately not reset.
module dmem_sram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-lane write; only enabled lanes change.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Read register only moves when asked, so it holds the last completed read.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts a level read/write request, answers LATENCY cycles later.
// Latency: ready pulses LATENCY cycles after the request is first presented; write commits leaving DONE.
// Backpressure: the core holds the enable until ready; dropping both enables in BUSY aborts the access.
// Optional: define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses via dmem_err.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_SIZE:0]  dmem_addr,
  input  logic                dmem_r_enable,
  input  logic                dmem_w_enable,
  input  logic [1:0]          dmem_w_size,
  input  logic [INSTR_SIZE:0] dmem_w_data,
  output logic [INSTR_SIZE:0] dmem_r_data,
  output logic                dmem_ready,
  output logic                dmem_err
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic          ready_q;
  logic          err_q;
  logic          rvld_q;

  logic          req;
  logic [AW+1:0] cur_addr;
  logic [1:0]    cur_size;
  logic          cur_err;
  logic          enter_done;

  logic          sram_re;
  logic          sram_we;
  logic [3:0]    sram_be;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  // Address bits above the word index wrap; they are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^dmem_addr[ADDR_SIZE:AW+2];

  assign req = dmem_r_enable | dmem_w_enable;

  // The access in flight: live inputs on the accepting cycle, captured copy afterwards.
  // Needed because with LATENCY=1 DONE is entered on the accepting edge itself.
  assign cur_addr = (state_q == ST_IDLE) ? dmem_addr[AW+1:0] : addr_q;
  assign cur_size = (state_q == ST_IDLE) ? dmem_w_size : size_q;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign cur_err = misaligned(cur_size, cur_addr[1:0]);
`else
  assign cur_err = 1'b0;
`endif

  // This edge moves the FSM into DONE: straight from IDLE when LATENCY is 1,
  // otherwise from BUSY on the last count, provided the core still holds a request.
  assign enter_done = req &&
                      (((state_q == ST_IDLE) && (LATENCY == 1)) ||
                       ((state_q == ST_BUSY) && (cnt_q == 4'd1)));

  // Responder FSM with registered ready/err and request capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      size_q  <= SIZE_BYTE;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (enter_done) begin
        ready_q <= 1'b1;
        err_q   <= cur_err;
        rvld_q  <= !cur_err;
      end
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= dmem_addr[AW+1:0];
            size_q  <= dmem_w_size;
            wdata_q <= dmem_w_data;
            wr_q    <= dmem_w_enable;
            if (LATENCY == 1) begin
              state_q <= ST_DONE;
              cnt_q   <= 4'd0;
            end else begin
              state_q <= ST_BUSY;
              cnt_q   <= LAT_M1;
            end
          end
        end
        ST_BUSY: begin
          if (!req) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q == 4'd1) begin
            state_q <= ST_DONE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          // Always drain through IDLE so a held request is not executed twice.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // Read the addressed word on the edge entering DONE (pre-write value for read+write).
  assign sram_re = enter_done && !cur_err;

  // Commit the write on the edge leaving DONE; flagged accesses never write.
  assign sram_we    = (state_q == ST_DONE) && wr_q && !err_q;
  assign sram_be    = lane_mask(size_q, addr_q[1:0]);
  assign sram_wdata = lane_data(size_q, wdata_q);

  dmem_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .re_i    (sram_re),
    .raddr_i (cur_addr[AW+1:2]),
    .rdata_o (sram_rdata),
    .we_i    (sram_we),
    .waddr_i (addr_q[AW+1:2]),
    .be_i    (sram_be),
    .wdata_i (sram_wdata)
  );

  // The SRAM read register has no reset; rvld_q masks it to zero after reset
  // and after a flagged completion.
  assign dmem_r_data = rvld_q ? sram_rdata : '0;
  assign dmem_ready  = ready_q;
  assign dmem_err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk           = 1'b0;
  logic        reset         = 1'b0;
  logic [31:0] dmem_addr     = 32'd0;
  logic        dmem_r_enable = 1'b0;
  logic        dmem_w_enable = 1'b0;
  logic [1:0]  dmem_w_size   = 2'd0;
  logic [31:0] dmem_w_data   = 32'd0;
  logic [31:0] dmem_r_data;
  logic        dmem_ready;
  logic        dmem_err;

  int total = 0;
  int bad   = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk           (clk),
    .reset         (reset),
    .dmem_addr     (dmem_addr),
    .dmem_r_enable (dmem_r_enable),
    .dmem_w_enable (dmem_w_enable),
    .dmem_w_size   (dmem_w_size),
    .dmem_w_data   (dmem_w_data),
    .dmem_r_data   (dmem_r_data),
    .dmem_ready    (dmem_ready),
    .dmem_err      (dmem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic r, input logic w,
                       input logic [1:0] sz, input logic [31:0] d);
    dmem_addr     = a;
    dmem_r_enable = r;
    dmem_w_enable = w;
    dmem_w_size   = sz;
    dmem_w_data   = d;
  endtask

  // One request held until ready; latency counts rising edges from presentation to ready.
  task automatic access(input string tag, input logic [31:0] a, input logic r, input logic w,
                        input logic [1:0] sz, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
    int lat;
    drive(a, r, w, sz, d);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dmem_ready && lat < 40);
    rd = dmem_r_data;
    er = dmem_err;
    drive(32'd0, 1'b0, 1'b0, 2'd0, 32'd0);
    chk({tag, ".lat"}, 32'(lat), 32'(LATENCY));
    @(negedge clk);
    chk({tag, ".pulse"}, {31'd0, dmem_ready}, 32'd0);
    chk({tag, ".err_idle"}, {31'd0, dmem_err}, 32'd0);
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] rd;
    logic        er;
    access(tag, a, 1'b0, 1'b1, sz, d, rd, er);
    chk({tag, ".err"}, {31'd0, er}, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    access(tag, a, 1'b1, 1'b0, SIZE_WORD, 32'd0, rd, er);
    chk({tag, ".data"}, rd, exp);
    chk({tag, ".err"}, {31'd0, er}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;
    int          first;
    int          second;

    // Reset state
    @(negedge clk);
    chk("rst.ready", {31'd0, dmem_ready}, 32'd0);
    chk("rst.err", {31'd0, dmem_err}, 32'd0);
    chk("rst.rdata", dmem_r_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Word write then read back
    wr("w_dead", 32'h10, SIZE_WORD, 32'hDEADBEEF);
    rd_chk("r_dead", 32'h10, 32'hDEADBEEF);

    // Byte and half lanes with replication
    wr("w_base", 32'h10, SIZE_WORD, 32'h11223344);
    wr("w_b13", 32'h13, SIZE_BYTE, 32'h000000AA);
    rd_chk("r_b13", 32'h10, 32'hAA223344);
    wr("w_h10", 32'h10, SIZE_HALF, 32'h00005566);
    rd_chk("r_h10", 32'h10, 32'hAA225566);
    wr("w_h12", 32'h12, SIZE_HALF, 32'h00007788);
    rd_chk("r_h12", 32'h10, 32'h77885566);
    wr("w_b11", 32'h11, SIZE_BYTE, 32'hFFFFFFCC);
    rd_chk("r_b11", 32'h10, 32'h7788CC66);

    // Read+write together returns the pre-write word
    access("rw", 32'h10, 1'b1, 1'b1, SIZE_WORD, 32'h0BADF00D, rd, er);
    chk("rw.data", rd, 32'h7788CC66);
    rd_chk("r_rw", 32'h10, 32'h0BADF00D);

    // Request held through DONE: one pulse per request, LATENCY+1 apart
    drive(32'h10, 1'b1, 1'b0, SIZE_WORD, 32'd0);
    n = 0; first = -1; second = -1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (dmem_ready) begin
        n++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
        chk("held.data", dmem_r_data, 32'h0BADF00D);
      end
    end
    drive(32'd0, 1'b0, 1'b0, 2'd0, 32'd0);
    chk("held.count", 32'(n), 32'd2);
    chk("held.first", 32'(first), 32'd2);
    chk("held.gap", 32'(second - first), 32'd3);
    @(negedge clk);
    @(negedge clk);

    // Reset in the middle of BUSY aborts the write
    wr("w_pre20", 32'h20, SIZE_WORD, 32'h11111111);
    rd_chk("r_pre20", 32'h20, 32'h11111111);
    drive(32'h20, 1'b0, 1'b1, SIZE_WORD, 32'h12345678);
    @(negedge clk);
    chk("rbusy.ready", {31'd0, dmem_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rbusy.rdata", dmem_r_data, 32'd0);
    chk("rbusy.err", {31'd0, dmem_err}, 32'd0);
    @(negedge clk);
    chk("rbusy.ready2", {31'd0, dmem_ready}, 32'd0);
    reset = 1'b1;
    drive(32'd0, 1'b0, 1'b0, 2'd0, 32'd0);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dmem_ready) n++;
    end
    chk("rbusy.no_ready", 32'(n), 32'd0);
    rd_chk("r_post20", 32'h20, 32'h11111111);

    // Enables dropped in BUSY: no ready, no write; address aliasing
    wr("w_pre8", 32'h8, SIZE_WORD, 32'h00000222);
    drive(32'h8, 1'b0, 1'b1, SIZE_WORD, 32'hCAFEF00D);
    @(negedge clk);
    drive(32'd0, 1'b0, 1'b0, 2'd0, 32'd0);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dmem_ready) n++;
    end
    chk("drop.no_ready", 32'(n), 32'd0);
    rd_chk("r_drop8", 32'h8, 32'h00000222);
    rd_chk("r_alias", 32'(4*DEPTH + 8), 32'h00000222);
    wr("w_alias", 32'(4*DEPTH + 8), SIZE_WORD, 32'h00000333);
    rd_chk("r_alias8", 32'h8, 32'h00000333);

    // Misaligned word write
    access("mis", 32'h22, 1'b0, 1'b1, SIZE_WORD, 32'hABCD0123, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("mis.err", {31'd0, er}, 32'd1);
    chk("mis.rdata", rd, 32'd0);
    rd_chk("r_mis20", 32'h20, 32'h11111111);
`else
    chk("mis.err", {31'd0, er}, 32'd0);
    rd_chk("r_mis20", 32'h20, 32'hABCD0123);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout sim_time got=expired exp=finished");
    $fatal(1, "time limit");
  end

endmodule
